// File: rtl/radix2_seq_div.sv
// -----------------------------------------------------------------------------
// radix2_seq_div
//
// Iterative radix-2 restoring signed divider with AXI-stream style channels.
// One dividend/divisor pair is accepted per operation. The result is a
// truncated integer quotient together with a signed fixed-point fraction,
// and both fields carry the sign of the true quotient (round toward zero).
//
// Internally the divider works on magnitudes. The numerator is
// |dividend| << FRAC_W, and one quotient bit is produced per clock. After the
// last iteration a fix-up cycle applies the sign and then registers the
// result beat. A request accepted in cycle k shows its result in cycle k+44
// at the default parameters.
//
// Ports:
//   clk                    : clock
//   rst                    : synchronous active-high reset (overrides clk_en)
//   clk_en                 : clock enable; low freezes every register
//   s_axis_divisor_tvalid  : divisor valid
//   s_axis_divisor_tready  : divisor ready (asserted together with dividend)
//   s_axis_divisor_tdata   : signed divisor, DIVISOR_W bits
//   s_axis_dividend_tvalid : dividend valid
//   s_axis_dividend_tready : dividend ready (asserted together with divisor)
//   s_axis_dividend_tdata  : signed dividend, DIVIDEND_W bits
//   m_axis_dout_tvalid     : result valid
//   m_axis_dout_tready     : result ready
//   m_axis_dout_tuser      : divide-by-zero flag
//   m_axis_dout_tdata      : {int_q[INT_W-1:0], frac[FRAC_W:0]}
// -----------------------------------------------------------------------------
module radix2_seq_div #(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR_W  = 32,
    parameter int FRAC_W     = 18,
    parameter int INT_W      = 21
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_en,
    input  logic                       s_axis_divisor_tvalid,
    output logic                       s_axis_divisor_tready,
    input  logic [DIVISOR_W-1:0]       s_axis_divisor_tdata,
    input  logic                       s_axis_dividend_tvalid,
    output logic                       s_axis_dividend_tready,
    input  logic [DIVIDEND_W-1:0]      s_axis_dividend_tdata,
    output logic                       m_axis_dout_tvalid,
    input  logic                       m_axis_dout_tready,
    output logic                       m_axis_dout_tuser,
    output logic [INT_W+FRAC_W:0]      m_axis_dout_tdata
);

    // Number of restoring iterations equals the numerator width.
    localparam int NUM_W = DIVIDEND_W + FRAC_W;
    localparam int OUT_W = INT_W + FRAC_W + 1;
    localparam int CNT_W = $clog2(NUM_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_OUT
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   accept;
    logic                   out_fire;

    logic [DIVIDEND_W-1:0]  dvd_abs;
    logic [DIVISOR_W-1:0]   dvs_abs;

    logic [DIVISOR_W-1:0]   dvs_mag;
    logic                   neg;
    logic                   dz;
    logic [CNT_W-1:0]       cnt;
    logic [DIVISOR_W-1:0]   rem;
    logic [NUM_W-1:0]       num;

    logic [DIVISOR_W:0]     rem_shift;
    logic                   rem_ge;

    logic [INT_W-1:0]       int_mag;
    logic [FRAC_W:0]        frac_ext;
    logic [INT_W-1:0]       int_q;
    logic [FRAC_W:0]        frac_q;

    logic [OUT_W-1:0]       dout_data;
    logic                   dout_user;

    // Both request channels handshake together in IDLE only; ready is
    // withheld while reset is asserted so nothing is captured then.
    assign accept   = (state == ST_IDLE) && clk_en && !rst &&
                      s_axis_divisor_tvalid && s_axis_dividend_tvalid;
    assign out_fire = (state == ST_OUT) && clk_en && m_axis_dout_tready;

    // Operand magnitudes. Negating the most negative value wraps to
    // 2^(W-1), which is exactly right when the result is read as unsigned.
    assign dvd_abs = s_axis_dividend_tdata[DIVIDEND_W-1] ?
                     -s_axis_dividend_tdata : s_axis_dividend_tdata;
    assign dvs_abs = s_axis_divisor_tdata[DIVISOR_W-1] ?
                     -s_axis_divisor_tdata : s_axis_divisor_tdata;

    // One restoring step: bring in the next numerator bit (MSB first) and
    // test whether the divisor fits. The remainder stays below |divisor|,
    // so DIVISOR_W bits hold it and one extra bit covers the shifted value.
    assign rem_shift = {rem, num[NUM_W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_mag});

    // Sign fix-up. The integer part and the fraction are negated separately
    // so each truncates toward zero. The integer field keeps only its low
    // INT_W bits, so large quotients wrap silently.
    assign int_mag  = INT_W'(num >> FRAC_W);
    assign frac_ext = {1'b0, num[FRAC_W-1:0]};
    assign int_q    = neg ? -int_mag  : int_mag;
    assign frac_q   = neg ? -frac_ext : frac_ext;

    // State register: reset wins over clk_en, and clk_en low holds the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, iterate, fix up, then hold the result until
    // the consumer takes it.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)            state_next = ST_CALC;
            ST_CALC: if (cnt == LAST_ITER)  state_next = ST_FIX;
            ST_FIX:                         state_next = ST_OUT;
            ST_OUT:  if (out_fire)          state_next = ST_IDLE;
            default:                        state_next = ST_IDLE;
        endcase
    end

    // Output logic: ready only on an IDLE handshake, valid for the whole
    // OUT state. The result fields come from registers written in FIX, so
    // they cannot change while valid is held.
    always_comb begin
        s_axis_divisor_tready  = accept;
        s_axis_dividend_tready = accept;
        m_axis_dout_tvalid     = (state == ST_OUT);
        m_axis_dout_tuser      = dout_user;
        m_axis_dout_tdata      = dout_data;
    end

    // Datapath registers. The numerator register doubles as the quotient
    // register: each step shifts a numerator bit out of the top and the new
    // quotient bit in at the bottom. After the final step it holds the
    // complete magnitude quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvs_mag   <= '0;
            neg       <= 1'b0;
            dz        <= 1'b0;
            cnt       <= '0;
            rem       <= '0;
            num       <= '0;
            dout_data <= '0;
            dout_user <= 1'b0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dvs_mag <= dvs_abs;
                        neg     <= s_axis_dividend_tdata[DIVIDEND_W-1] ^
                                   s_axis_divisor_tdata[DIVISOR_W-1];
                        dz      <= (s_axis_divisor_tdata == '0);
                        cnt     <= '0;
                        rem     <= '0;
                        num     <= {dvd_abs, {FRAC_W{1'b0}}};
                    end
                end
                ST_CALC: begin
                    if (rem_ge) begin
                        rem <= DIVISOR_W'(rem_shift - {1'b0, dvs_mag});
                    end else begin
                        rem <= DIVISOR_W'(rem_shift);
                    end
                    num <= {num[NUM_W-2:0], rem_ge};
                    cnt <= cnt + 1'b1;
                end
                ST_FIX: begin
                    if (dz) begin
                        dout_data <= '0;
                        dout_user <= 1'b1;
                    end else begin
                        dout_data <= {int_q, frac_q};
                        dout_user <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix2_seq_div.sv
// -----------------------------------------------------------------------------
// tb_radix2_seq_div
//
// Directed bench for radix2_seq_div. It applies a table of operand pairs with
// hand-computed quotients and then runs multi-cycle sequences: a lone divisor
// valid, output backpressure, clk_en freezes, and a reset during an operation.
// -----------------------------------------------------------------------------
module tb_radix2_seq_div;

    localparam int DIVIDEND_W = 24;
    localparam int DIVISOR_W  = 32;
    localparam int FRAC_W     = 18;
    localparam int INT_W      = 21;
    localparam int OUT_W      = INT_W + FRAC_W + 1;
    localparam int LATENCY    = 43;
    localparam int WAIT_LIMIT = 200;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clk_en;
    logic                  s_axis_divisor_tvalid;
    logic                  s_axis_divisor_tready;
    logic [DIVISOR_W-1:0]  s_axis_divisor_tdata;
    logic                  s_axis_dividend_tvalid;
    logic                  s_axis_dividend_tready;
    logic [DIVIDEND_W-1:0] s_axis_dividend_tdata;
    logic                  m_axis_dout_tvalid;
    logic                  m_axis_dout_tready;
    logic                  m_axis_dout_tuser;
    logic [OUT_W-1:0]      m_axis_dout_tdata;

    int num_compared   = 0;
    int num_mismatched = 0;

    typedef struct {
        string                 name;
        logic [DIVIDEND_W-1:0] dvd;
        logic [DIVISOR_W-1:0]  dvs;
        logic [INT_W-1:0]      exp_int;
        logic [FRAC_W:0]       exp_frac;
        logic                  exp_user;
    } vec_t;

    vec_t vecs[11];

    radix2_seq_div #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W),
        .FRAC_W     (FRAC_W),
        .INT_W      (INT_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .clk_en                 (clk_en),
        .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
        .s_axis_divisor_tready  (s_axis_divisor_tready),
        .s_axis_divisor_tdata   (s_axis_divisor_tdata),
        .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
        .s_axis_dividend_tready (s_axis_dividend_tready),
        .s_axis_dividend_tdata  (s_axis_dividend_tdata),
        .m_axis_dout_tvalid     (m_axis_dout_tvalid),
        .m_axis_dout_tready     (m_axis_dout_tready),
        .m_axis_dout_tuser      (m_axis_dout_tuser),
        .m_axis_dout_tdata      (m_axis_dout_tdata)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string what, input logic [63:0] actual,
                               input logic [63:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DIVIDEND_W-1:0] dvd,
                                 input logic [DIVISOR_W-1:0] dvs);
        s_axis_dividend_tdata  = dvd;
        s_axis_divisor_tdata   = dvs;
        s_axis_dividend_tvalid = 1'b1;
        s_axis_divisor_tvalid  = 1'b1;
    endtask

    task automatic dropStimulus();
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
    endtask

    // Bounded wait for the result; a timeout shows up as a latency mismatch.
    task automatic waitValid(output int n);
        n = 0;
        while (!m_axis_dout_tvalid && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
    endtask

    task automatic checkResult(input string name, input logic [INT_W-1:0] exp_int,
                               input logic [FRAC_W:0] exp_frac, input logic exp_user);
        checkOutput({name, " tvalid"}, 64'(m_axis_dout_tvalid), 64'd1);
        checkOutput({name, " int_q"}, 64'(m_axis_dout_tdata[OUT_W-1:FRAC_W+1]), 64'(exp_int));
        checkOutput({name, " frac"}, 64'(m_axis_dout_tdata[FRAC_W:0]), 64'(exp_frac));
        checkOutput({name, " tuser"}, 64'(m_axis_dout_tuser), 64'(exp_user));
    endtask

    task automatic drainOutput(input string name);
        m_axis_dout_tready = 1'b1;
        tick();
        m_axis_dout_tready = 1'b0;
        checkOutput({name, " tvalid_drop"}, 64'(m_axis_dout_tvalid), 64'd0);
    endtask

    // Full operation: handshake, optional clk_en freeze 10 cycles into CALC,
    // latency check, result check and output handshake.
    task automatic runOp(input string name, input logic [DIVIDEND_W-1:0] dvd,
                         input logic [DIVISOR_W-1:0] dvs, input logic [INT_W-1:0] exp_int,
                         input logic [FRAC_W:0] exp_frac, input logic exp_user,
                         input int freeze_len);
        int n;
        int total;
        applyStimulus(dvd, dvs);
        #1;
        checkOutput({name, " accept_ready"},
                    64'({s_axis_dividend_tready, s_axis_divisor_tready}), 64'd3);
        tick();
        dropStimulus();
        total = 0;
        if (freeze_len > 0) begin
            repeat (10) tick();
            clk_en = 1'b0;
            repeat (freeze_len) tick();
            clk_en = 1'b1;
            total = 10 + freeze_len;
        end
        waitValid(n);
        total += n;
        checkOutput({name, " latency"}, 64'(total), 64'(LATENCY + freeze_len));
        checkResult(name, exp_int, exp_frac, exp_user);
        drainOutput(name);
    endtask

    initial begin
        int n;
        logic [OUT_W-1:0] held;

        // Hand-computed vectors. Fields are {int_q 21b, frac 19b} two's complement.
        vecs[0]  = '{"7/2",        24'd7,         32'd2,          21'd3,        19'h20000, 1'b0};
        vecs[1]  = '{"-7/2",       -24'sd7,       32'd2,          21'h1FFFFD,   19'h60000, 1'b0};
        vecs[2]  = '{"7/-2",       24'd7,         -32'sd2,        21'h1FFFFD,   19'h60000, 1'b0};
        vecs[3]  = '{"-7/-2",      -24'sd7,       -32'sd2,        21'd3,        19'h20000, 1'b0};
        vecs[4]  = '{"1/3",        24'd1,         32'd3,          21'd0,        19'd87381, 1'b0};
        vecs[5]  = '{"min/min",    24'h800000,    32'h80000000,   21'd0,        19'h00400, 1'b0};
        vecs[6]  = '{"5/0",        24'd5,         32'd0,          21'd0,        19'd0,     1'b1};
        vecs[7]  = '{"100/7",      24'd100,       32'd7,          21'd14,       19'h12492, 1'b0};
        vecs[8]  = '{"-1000/3",    -24'sd1000,    32'd3,          21'h1FFEB3,   19'h6AAAB, 1'b0};
        vecs[9]  = '{"min/1 wrap", 24'h800000,    32'd1,          21'd0,        19'd0,     1'b0};
        vecs[10] = '{"max/max",    24'h7FFFFF,    32'h7FFFFFFF,   21'd0,        19'h003FF, 1'b0};

        rst                = 1'b1;
        clk_en             = 1'b1;
        m_axis_dout_tready = 1'b0;
        s_axis_dividend_tdata = '0;
        s_axis_divisor_tdata  = '0;
        applyStimulus(24'd7, 32'd2);
        repeat (3) tick();

        // Reset state, with both request valids high to show nothing is taken.
        checkOutput("reset tvalid", 64'(m_axis_dout_tvalid), 64'd0);
        checkOutput("reset tuser", 64'(m_axis_dout_tuser), 64'd0);
        checkOutput("reset tdata", 64'(m_axis_dout_tdata), 64'd0);
        checkOutput("reset treadys",
                    64'({s_axis_dividend_tready, s_axis_divisor_tready}), 64'd0);
        dropStimulus();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            runOp(vecs[i].name, vecs[i].dvd, vecs[i].dvs, vecs[i].exp_int,
                  vecs[i].exp_frac, vecs[i].exp_user, 0);
        end

        // Divisor valid alone must never handshake.
        s_axis_divisor_tdata  = 32'd2;
        s_axis_divisor_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("lone divisor treadys",
                        64'({s_axis_dividend_tready, s_axis_divisor_tready}), 64'd0);
            tick();
        end
        checkOutput("lone divisor no result", 64'(m_axis_dout_tvalid), 64'd0);

        // clk_en low in IDLE blocks the handshake even with both valids.
        clk_en = 1'b0;
        applyStimulus(24'd7, 32'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("clk_en idle treadys",
                        64'({s_axis_dividend_tready, s_axis_divisor_tready}), 64'd0);
            tick();
        end
        clk_en = 1'b1;

        // Single accept, then backpressure on the result channel.
        #1;
        checkOutput("bp accept_ready",
                    64'({s_axis_dividend_tready, s_axis_divisor_tready}), 64'd3);
        tick();
        dropStimulus();
        waitValid(n);
        checkOutput("bp latency", 64'(n), 64'(LATENCY));
        held = {21'd3, 19'h20000};
        applyStimulus(24'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp tvalid held", 64'(m_axis_dout_tvalid), 64'd1);
            checkOutput("bp tdata stable", 64'(m_axis_dout_tdata), 64'(held));
            checkOutput("bp s treadys",
                        64'({s_axis_dividend_tready, s_axis_divisor_tready}), 64'd0);
            tick();
        end

        // clk_en low while the result waits: ready high must not complete it.
        clk_en             = 1'b0;
        m_axis_dout_tready = 1'b1;
        repeat (2) tick();
        checkOutput("frozen out tvalid", 64'(m_axis_dout_tvalid), 64'd1);
        checkOutput("frozen out tdata", 64'(m_axis_dout_tdata), 64'(held));
        clk_en = 1'b1;
        #1;
        checkOutput("bp ready_at_fire",
                    64'({s_axis_dividend_tready, s_axis_divisor_tready}), 64'd0);
        tick();
        m_axis_dout_tready = 1'b0;
        checkOutput("bp tvalid_drop", 64'(m_axis_dout_tvalid), 64'd0);
        checkOutput("bp next accept",
                    64'({s_axis_dividend_tready, s_axis_divisor_tready}), 64'd3);
        tick();
        dropStimulus();
        waitValid(n);
        checkOutput("bp next latency", 64'(n), 64'(LATENCY));
        checkResult("bp next 100/7", 21'd14, 19'h12492, 1'b0);
        drainOutput("bp next");

        // clk_en low for 5 cycles mid-CALC delays the result by 5.
        runOp("freeze -7/2", -24'sd7, 32'd2, 21'h1FFFFD, 19'h60000, 1'b0, 5);

        // Reset in cycle k+20 discards the operation in flight.
        applyStimulus(24'd1, 32'd3);
        #1;
        checkOutput("rst accept_ready",
                    64'({s_axis_dividend_tready, s_axis_divisor_tready}), 64'd3);
        tick();
        dropStimulus();
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst mid tvalid", 64'(m_axis_dout_tvalid), 64'd0);
        checkOutput("rst mid tdata", 64'(m_axis_dout_tdata), 64'd0);
        runOp("after rst 7/-2", 24'd7, -32'sd2, 21'h1FFFFD, 19'h60000, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
